red_pitaya_enable_seq: RTL and testbench

//  Enable sequencer that drives the enable_i inputs of N sub-module reset/clock-enable controllers.

---
 rtl/red_pitaya_enable_seq.sv | 115 +++++++++++
 tb/tb_red_pitaya_enable_seq.sv | 106 ++++++++++
 2 files changed

// File: rtl/red_pitaya_enable_seq.sv
// red_pitaya_enable_seq: steps per-channel enables toward a requested mask one channel at a time,
// disables highest-first then enables lowest-first, holding SETTLE cycles after each toggle.
module red_pitaya_enable_seq #(
  parameter int N_SUB  = 4,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid_i,
  input  logic [N_SUB-1:0] req_mask_i,
  output logic [N_SUB-1:0] enable_o,
  output logic [N_SUB-1:0] status_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int IW = N_SUB > 1 ? $clog2(N_SUB) : 1;
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {IDLE, SELECT, WAIT} state_t;
  state_t state, state_n;
  logic [N_SUB-1:0] target, target_n, pend_mask, pend_mask_n, enable_n, status_n;
  logic pend_valid, pend_valid_n, busy_n, done_n, up, up_n, dis_hit, en_hit;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] ch, ch_n, dis_idx, en_idx;
  always_comb begin
    dis_hit = 1'b0;
    dis_idx = '0;
    en_hit = 1'b0;
    en_idx = '0;
    for (int i = 0; i < N_SUB; i++)
      if (enable_o[i] && !target[i]) begin
        dis_hit = 1'b1;
        dis_idx = IW'(i);
      end
    for (int i = N_SUB - 1; i >= 0; i--)
      if (!enable_o[i] && target[i]) begin
        en_hit = 1'b1;
        en_idx = IW'(i);
      end
  end
  always_comb begin
    state_n = state;
    target_n = target;
    pend_valid_n = pend_valid;
    pend_mask_n = pend_mask;
    enable_n = enable_o;
    status_n = status_o;
    busy_n = busy_o;
    done_n = 1'b0;
    cnt_n = cnt;
    ch_n = ch;
    up_n = up;
    case (state)
      IDLE: if (req_valid_i) begin
        target_n = req_mask_i;
        busy_n = 1'b1;
        state_n = SELECT;
      end
      SELECT: begin
        if (dis_hit || en_hit) begin
          ch_n = dis_hit ? dis_idx : en_idx;
          up_n = !dis_hit;
          enable_n[ch_n] = !dis_hit;
          status_n[ch_n] = 1'b0;
          cnt_n = CW'(SETTLE - 1);
          state_n = WAIT;
          pend_valid_n = pend_valid || req_valid_i;
          pend_mask_n = req_valid_i ? req_mask_i : pend_mask;
        end else if (req_valid_i || pend_valid) begin
          target_n = req_valid_i ? req_mask_i : pend_mask;
          pend_valid_n = 1'b0;
        end else begin
          busy_n = 1'b0;
          done_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        pend_valid_n = pend_valid || req_valid_i;
        pend_mask_n = req_valid_i ? req_mask_i : pend_mask;
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
        if (cnt == '0) begin
          status_n[ch] = status_o[ch] || up;
          state_n = SELECT;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      target <= '0;
      pend_valid <= 1'b0;
      pend_mask <= '0;
      enable_o <= '0;
      status_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      cnt <= '0;
      ch <= '0;
      up <= 1'b0;
    end else begin
      state <= state_n;
      target <= target_n;
      pend_valid <= pend_valid_n;
      pend_mask <= pend_mask_n;
      enable_o <= enable_n;
      status_o <= status_n;
      busy_o <= busy_n;
      done_o <= done_n;
      cnt <= cnt_n;
      ch <= ch_n;
      up <= up_n;
    end
  end
endmodule

// File: tb/tb_red_pitaya_enable_seq.sv
// tb_red_pitaya_enable_seq: directed sequences with a cycle-indexed scoreboard of expected outputs.
module tb_red_pitaya_enable_seq;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req_valid_i = 1'b0;
  logic [3:0] req_mask_i = '0;
  logic [3:0] enable_o, status_o;
  logic busy_o, done_o;
  typedef struct {int k; logic [9:0] exp;} chk_t;
  typedef struct {int k; logic [3:0] m;} inj_t;
  chk_t q[$];
  inj_t inj[$];
  int tests = 0, fails = 0, dones = 0;
  red_pitaya_enable_seq #(.N_SUB(4), .SETTLE(4)) dut (
    .clk(clk), .rstn(rstn), .req_valid_i(req_valid_i), .req_mask_i(req_mask_i),
    .enable_o(enable_o), .status_o(status_o), .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] obs();
    return {enable_o, status_o, busy_o, done_o};
  endfunction
  task automatic check(input string tag, input int k, input logic [9:0] exp);
    tests++;
    assert (obs() === exp) else begin
      fails++;
      $error("FAIL %s k=%0d en/st/busy/done got %b want %b", tag, k, obs(), exp);
    end
  endtask
  task automatic ex(input int k, input logic [3:0] en, input logic [3:0] st, input logic b, input logic d);
    q.push_back('{k, {en, st, b, d}});
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rstn = 1'b0;
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask
  task automatic run(input logic [3:0] mask, input int last, input string tag);
    chk_t e;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_mask_i = mask;
    dones = 0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      dones += int'(done_o);
      while (q.size() > 0 && q[0].k == k) begin
        e = q.pop_front();
        check(tag, k, e.exp);
      end
      if (inj.size() > 0 && inj[0].k == k) begin
        req_valid_i = 1'b1;
        req_mask_i = inj[0].m;
        void'(inj.pop_front());
      end
    end
    q.delete();
    inj.delete();
  endtask
  initial begin
    reset_dut();
    check("reset", 0, 10'b0);
    ex(0, 4'b0000, 4'b0000, 1, 0); ex(1, 4'b0001, 4'b0000, 1, 0); ex(4, 4'b0001, 4'b0000, 1, 0);
    ex(5, 4'b0001, 4'b0001, 1, 0); ex(6, 4'b0101, 4'b0001, 1, 0); ex(9, 4'b0101, 4'b0001, 1, 0);
    ex(10, 4'b0101, 4'b0101, 1, 0); ex(11, 4'b0101, 4'b0101, 0, 1); ex(12, 4'b0101, 4'b0101, 0, 0);
    run(4'b0101, 12, "t1_0101");
    ex(11, 4'b1111, 4'b1111, 0, 1);
    run(4'b1111, 12, "t2_pre");
    ex(1, 4'b0111, 4'b0111, 1, 0); ex(5, 4'b0111, 4'b0111, 1, 0); ex(6, 4'b0110, 4'b0110, 1, 0);
    ex(10, 4'b0110, 4'b0110, 1, 0); ex(11, 4'b0110, 4'b0110, 0, 1);
    run(4'b0110, 12, "t2_0110");
    ex(1, 4'b0010, 4'b0010, 1, 0); ex(11, 4'b0001, 4'b0000, 1, 0); ex(16, 4'b0001, 4'b0001, 0, 1);
    run(4'b0001, 17, "t3_pre");
    ex(1, 4'b0000, 4'b0000, 1, 0); ex(6, 4'b1000, 4'b0000, 1, 0); ex(10, 4'b1000, 4'b1000, 1, 0);
    ex(11, 4'b1000, 4'b1000, 0, 1);
    run(4'b1000, 12, "t3_1000");
    reset_dut();
    inj.push_back('{2, 4'b0100}); inj.push_back('{7, 4'b1100});
    ex(10, 4'b0011, 4'b0011, 1, 0); ex(11, 4'b0011, 4'b0011, 1, 0); ex(12, 4'b0001, 4'b0001, 1, 0);
    ex(17, 4'b0000, 4'b0000, 1, 0); ex(22, 4'b0100, 4'b0000, 1, 0); ex(26, 4'b0100, 4'b0100, 1, 0);
    ex(27, 4'b1100, 4'b0100, 1, 0); ex(31, 4'b1100, 4'b1100, 1, 0); ex(32, 4'b1100, 4'b1100, 0, 1);
    ex(33, 4'b1100, 4'b1100, 0, 0);
    run(4'b0011, 34, "t4_pend");
    tests++;
    assert (dones === 1) else begin
      fails++;
      $error("FAIL t4_done_count got %0d want 1", dones);
    end
    reset_dut();
    ex(6, 4'b0011, 4'b0001, 1, 0); ex(7, 4'b0011, 4'b0001, 1, 0);
    run(4'b0011, 7, "t5_pre");
    rstn = 1'b0;
    @(negedge clk);
    check("t5_reset", 8, 10'b0);
    rstn = 1'b1;
    ex(1, 4'b0100, 4'b0000, 1, 0); ex(5, 4'b0100, 4'b0100, 1, 0); ex(6, 4'b0100, 4'b0100, 0, 1);
    run(4'b0100, 7, "t5_after");
    reset_dut();
    ex(0, 4'b0000, 4'b0000, 1, 0); ex(1, 4'b0000, 4'b0000, 0, 1); ex(2, 4'b0000, 4'b0000, 0, 0);
    run(4'b0000, 2, "t6_same");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
